mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline.
- Sits in the execute stage beside the ALU and executes MULT, MULTU, DIV and DIVU.
- Holds the pipeline with a stall output while an operation runs.
- Supports direct HI/LO writes (MTHI/MTLO) and flush-driven abort.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, reset; asynchronous and active-low (0 = reset).
- start, input, 1, execute-stage MDU instruction valid; held high while stall is high.
- op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a, input, WIDTH, rs operand (dividend / multiplicand).
- b, input, WIDTH, rt operand (divisor / multiplier).
- flush, input, 1, abort the current operation (exception or execute-stage flush).
- hi_we, input, 1, MTHI write enable.
- lo_we, input, 1, MTLO write enable.
- wdata, input, WIDTH, data for MTHI/MTLO.
- stall, output, 1, combinational pipeline hold request.
- busy, output, 1, registered; high while in RUN.
- done, output, 1, registered; one-cycle completion pulse.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - hi, lo, busy, done, counter and working registers all go to 0.
- IDLE:
  - start=1 and flush=0 → latch |a|, |b| (signed ops), the result sign, the remainder sign and op; counter=WIDTH; go to RUN.
  - flush=1 in the same cycle as start → stay IDLE; operands are not latched.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter decrements each step; when it reaches 0, go to DONE.
- DONE:
  - Apply sign correction.
  - Multiply: {hi,lo} = full 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - done=1 for exactly this cycle; the next state is always IDLE.
  - start is ignored in DONE, so a held start does not retrigger.
- Latency: start seen in IDLE at cycle 0 → done and hi/lo updated at cycle WIDTH+1; results are readable by the next instruction.
- stall = (start & state==IDLE & ~flush) | (state==RUN). stall is 0 in DONE, which lets the pipeline advance.
- busy = (state==RUN).
- Divide by zero:
  - lo = all ones; hi = a (raw dividend).
  - Fixed latency; no exception is raised.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- Flush in RUN → IDLE next cycle; hi/lo unchanged; done not asserted.
- Direct writes (hi_we / lo_we):
  - Applied in any cycle; the register updates with wdata on that edge.
  - In the DONE cycle the operation result wins over hi_we/lo_we.
  - A write during RUN updates HI/LO immediately; that value is then overwritten in DONE.
- Operands are sampled only at start; later changes on a or b have no effect.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined:
  - MULT and MULTU compute the product in one cycle: IDLE → DONE directly, skipping RUN.
  - done and hi/lo land at cycle 1.
  - stall is high only in the start cycle.
  - Divides are unchanged.
- Undefined: multiply is iterative, WIDTH+1 cycles, same as divide.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFE (-2), b=3 → done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall high cycles 0..32, low at 33.
- DIVU a=100, b=7 → lo=14, hi=2. Then DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, no hang.
- Start MULTU, assert flush at cycle 10 → IDLE at cycle 11, done never pulses, hi/lo keep prior values; start held through DONE does not retrigger.
- Drive rst=0 mid-RUN asynchronously → all outputs 0 immediately. With MDU_FAST_MULT_EN: MULTU 0xFFFFFFFF*0xFFFFFFFF → done at cycle 1, hi=0xFFFFFFFE, lo=0x00000001.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Execute-stage <-> multiply/divide unit bus for mdu_iterative.
// The pipeline is the master; the MDU is the slave.
`timescale 1ns/1ps
interface mdu_iterative_if #(
   parameter int WIDTH = 32
);
   // Handshake: start is the request and stays high while stall is high.
   // The request is accepted on the first edge where start=1, flush=0 and the
   // unit is idle. done pulses for one cycle together with the new hi/lo.
   // flush may abort an accepted request at any point before done.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush, hi_we, lo_we, wdata,
      input  stall, busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush, hi_we, lo_we, wdata,
      output stall, busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Define MDU_FAST_MULT_EN to turn multiplies into a single-cycle operation.
`timescale 1ns/1ps
module mdu_iterative #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   mdu_iterative_if.slave    bus,
   output logic [1:0]        dbg_state_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q, mq_q, opd_q, hi_q, lo_q;
   logic             is_div_q, neg_res_q, neg_rem_q, div0_q, busy_q, done_q;

   logic             sgn_a, sgn_b;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign sgn_a = ~bus.op[0] & bus.a[WIDTH-1];
   assign sgn_b = ~bus.op[0] & bus.b[WIDTH-1];
   assign abs_a = sgn_a ? -bus.a : bus.a;
   assign abs_b = sgn_b ? -bus.b : bus.b;

   // acc_q is the upper product half (multiply) or partial remainder (divide);
   // mq_q holds the multiplier bits or the dividend/quotient shift register.
   logic [WIDTH:0]     sum, shifted;
   logic               ge;
   logic [WIDTH-1:0]   acc_d, mq_d, quo, rem, hi_d, lo_d;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opd_q} : '0);
      shifted = {acc_q, mq_q[WIDTH-1]};
      ge      = shifted >= {1'b0, opd_q};
      if (is_div_q) begin
         acc_d = ge ? (shifted[WIDTH-1:0] - opd_q) : shifted[WIDTH-1:0];
         mq_d  = {mq_q[WIDTH-2:0], ge};
      end else begin
         acc_d = sum[WIDTH:1];
         mq_d  = {sum[0], mq_q[WIDTH-1:1]};
      end
      prod = {acc_d, mq_d};
      if (neg_res_q) prod = -prod;
      quo = neg_res_q ? -mq_d : mq_d;
      if (div0_q) quo = '1;
      // With a zero divisor the remainder path returns |a|, so sign-correcting it yields raw a.
      rem  = neg_rem_q ? -acc_d : acc_d;
      hi_d = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = is_div_q ? quo : prod[WIDTH-1:0];
   end

`ifdef MDU_FAST_MULT_EN
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
   assign ext_a     = {{WIDTH{sgn_a}}, bus.a};
   assign ext_b     = {{WIDTH{sgn_b}}, bus.b};
   assign fast_prod = ext_a * ext_b;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         opd_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.hi_we) hi_q <= bus.wdata;
         if (bus.lo_we) lo_q <= bus.wdata;
         case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.flush) begin
`ifdef MDU_FAST_MULT_EN
                  if (!bus.op[1]) begin
                     hi_q    <= fast_prod[2*WIDTH-1:WIDTH];
                     lo_q    <= fast_prod[WIDTH-1:0];
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else
`endif
                  begin
                     is_div_q  <= bus.op[1];
                     neg_res_q <= sgn_a ^ sgn_b;
                     neg_rem_q <= bus.op[1] & sgn_a;
                     div0_q    <= bus.op[1] & (bus.b == '0);
                     acc_q     <= '0;
                     mq_q      <= bus.op[1] ? abs_a : abs_b;
                     opd_q     <= bus.op[1] ? abs_b : abs_a;
                     cnt_q     <= CNT_W'(WIDTH);
                     busy_q    <= 1'b1;
                     state_q   <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (bus.flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= acc_d;
                  mq_q  <= mq_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  // Final step: the result lands with done and overrides any MTHI/MTLO.
                  if (cnt_q == CNT_W'(1)) begin
                     hi_q    <= hi_d;
                     lo_q    <= lo_d;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.stall   = (bus.start && (state_q == S_IDLE) && !bus.flush) || (state_q == S_RUN);
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed cases, flush, direct writes,
// asynchronous reset and randomized operations against an arithmetic model.
`timescale 1ns/1ps
module tb_mdu_iterative;
   localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mdu_iterative_if #(.WIDTH(W)) bus ();
   logic [1:0] dbg_state;

   mdu_iterative #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] exp_q[$];

   // reference model: {hi, lo} straight from the MIPS arithmetic rules
   function automatic logic [2*W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint          sp;
      longint unsigned up;
      int              sq, sr;
      case (op)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
         end
         2'b01: begin
            up = {32'h0, a} * {32'h0, b};
            return up;
         end
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op);
      return (FAST && !op[1]) ? 1 : W + 1;
   endfunction

   // driver: issue one op, hold start through DONE, record what happens
   task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int stall_end,
                        output logic [W-1:0] hi_v, output logic [W-1:0] lo_v, output logic busy_after);
      @(negedge clk);
      bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
      lat = -1; stall_end = -1; hi_v = '0; lo_v = '0; busy_after = 1'b1;
      #1;
      if (!bus.stall) stall_end = 0;
      for (int c = 1; c <= W + 10 && lat < 0; c++) begin
         @(negedge clk);
         bus.a = $urandom; bus.b = $urandom;
         if (!bus.stall && stall_end < 0) stall_end = c;
         if (bus.done) begin
            lat = c; hi_v = bus.hi; lo_v = bus.lo;
         end
      end
      if (lat >= 0) begin
         @(negedge clk);
         busy_after = bus.busy | bus.done;
      end
      bus.start = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      #3;
      total++; if (bus.hi !== '0) begin bad++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
      total++; if (bus.lo !== '0) begin bad++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_directed;
      logic [1:0]   ops[8] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
      logic [W-1:0] as[8]  = '{32'hFFFF_FFFE, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0000};
      logic [W-1:0] bs[8]  = '{32'd3, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
      int lat, stall_end;
      logic [W-1:0] hi_v, lo_v;
      logic busy_after;
      logic [2*W-1:0] want;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(ref_model(ops[i], as[i], bs[i]));
         do_op(ops[i], as[i], bs[i], lat, stall_end, hi_v, lo_v, busy_after);
         want = exp_q.pop_front();
         total++; if (lat !== exp_lat(ops[i])) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(ops[i])); end
         total++; if (stall_end !== exp_lat(ops[i])) begin bad++; $display("FAIL dir%0d_stall_end: got %0d want %0d", i, stall_end, exp_lat(ops[i])); end
         total++; if ({hi_v, lo_v} !== want) begin bad++; $display("FAIL dir%0d_result: got %h_%h want %h", i, hi_v, lo_v, want); end
         total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL dir%0d_retrigger: got busy %b want 0", i, busy_after); end
         idle_cycles(1);
      end
   endtask

   task automatic test_direct_write;
      logic [W-1:0] x, y;
      logic [2*W-1:0] want;
      int lat;
      x = $urandom; y = $urandom;
      @(negedge clk);
      bus.hi_we = 1'b1; bus.wdata = x;
      @(negedge clk);
      bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = ~x;
      total++; if (bus.hi !== x) begin bad++; $display("FAIL mthi_idle: got %h want %h", bus.hi, x); end
      @(negedge clk);
      bus.lo_we = 1'b0;
      total++; if (bus.lo !== ~x) begin bad++; $display("FAIL mtlo_idle: got %h want %h", bus.lo, ~x); end
      total++; if (bus.hi !== x) begin bad++; $display("FAIL mthi_hold: got %h want %h", bus.hi, x); end
      // write during RUN, later replaced by the divide result
      exp_q.push_back(ref_model(2'b11, 32'd1000, 32'd3));
      bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
      lat = -1;
      for (int c = 1; c <= W + 10 && lat < 0; c++) begin
         @(negedge clk);
         bus.hi_we = (c == 5); bus.lo_we = (c == 5); bus.wdata = y;
         if (c == 6) begin
            total++; if (bus.hi !== y) begin bad++; $display("FAIL mthi_run: got %h want %h", bus.hi, y); end
            total++; if (bus.lo !== y) begin bad++; $display("FAIL mtlo_run: got %h want %h", bus.lo, y); end
         end
         if (bus.done) lat = c;
      end
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      want = exp_q.pop_front();
      total++; if (lat !== W + 1) begin bad++; $display("FAIL wr_run_latency: got %0d want %0d", lat, W + 1); end
      total++; if ({bus.hi, bus.lo} !== want) begin bad++; $display("FAIL wr_run_result: got %h_%h want %h", bus.hi, bus.lo, want); end
      idle_cycles(2);
   endtask

   task automatic test_flush;
      logic [W-1:0] hi0, lo0;
      logic [1:0] op;
      int dones;
      op = FAST ? 2'b11 : 2'b01;
      hi0 = bus.hi; lo0 = bus.lo;
      // flush in the start cycle: not accepted
      @(negedge clk);
      bus.op = op; bus.a = $urandom; bus.b = $urandom; bus.start = 1'b1; bus.flush = 1'b1;
      #1;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_start_stall: got %b want 0", bus.stall); end
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy: got %b want 0", bus.busy); end
      // flush at cycle 10 of a running op
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'h1234_5678;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      bus.flush = 1'b1; bus.start = 1'b0;
      @(negedge clk);
      bus.flush = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_run_busy: got %b want 0", bus.busy); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL flush_run_state: got %0d want 0", dbg_state); end
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL flush_done: got %0d pulses want 0", dones); end
      total++; if (bus.hi !== hi0) begin bad++; $display("FAIL flush_hi: got %h want %h", bus.hi, hi0); end
      total++; if (bus.lo !== lo0) begin bad++; $display("FAIL flush_lo: got %h want %h", bus.lo, lo0); end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      bus.op = 2'b11; bus.a = $urandom; bus.b = $urandom_range(1, 1000); bus.start = 1'b1;
      for (int c = 1; c <= 7; c++) @(negedge clk);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", bus.busy); end
      #2;
      rst = 1'b0; bus.start = 1'b0;
      #1;
      total++; if (bus.hi !== '0) begin bad++; $display("FAIL arst_hi: got %h want 0", bus.hi); end
      total++; if (bus.lo !== '0) begin bad++; $display("FAIL arst_lo: got %h want 0", bus.lo); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL arst_stall: got %b want 0", bus.stall); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL arst_state: got %0d want 0", dbg_state); end
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_random;
      logic [1:0]   op;
      logic [W-1:0] a, b, hi_v, lo_v;
      logic [2*W-1:0] want;
      logic busy_after;
      int lat, stall_end;
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
         exp_q.push_back(ref_model(op, a, b));
         do_op(op, a, b, lat, stall_end, hi_v, lo_v, busy_after);
         want = exp_q.pop_front();
         total++; if (lat !== exp_lat(op)) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat(op)); end
         total++; if ({hi_v, lo_v} !== want) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h want %h", i, op, a, b, hi_v, lo_v, want); end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      test_reset();
      test_directed();
      test_direct_write();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
